// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PC = 32'hbfc0_0000;

    // Misaligned fetch, or a user-mode access to the kernel half of the map.
    function automatic logic exc_check(input logic [31:0] pc, input logic usermode);
        return (pc[1:0] != 2'b00) || (usermode && pc[31]);
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC and a single-outstanding
// instruction-bus handshake, with stall buffering and redirect draining.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        is_usermode,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_ready,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus4,
    output logic [31:0] out_instr,
    output logic        out_exc
);

    fetch_state_t state_r;
    fetch_state_t next_state_s;
    logic [31:0]  pc_r;
    logic [31:0]  next_pc_s;
    logic [31:0]  buf_r;
    logic         buf_load_s;
    logic         exc_s;
    logic         accept_s;

    assign exc_s       = exc_check(pc_r, is_usermode);
    assign ireq_addr   = pc_r;
    assign out_pc      = pc_r;
    assign out_pcplus4 = pc_r + 32'd4;
    assign accept_s    = out_valid && !stall;

    // Bus request and decode-side outputs; WAIT bypasses the response straight through.
    always_comb begin
        ireq_valid = 1'b0;
        out_valid  = 1'b0;
        out_exc    = 1'b0;
        out_instr  = 32'd0;
        case (state_r)
            REQ: begin
                if (exc_s) begin
                    out_valid = 1'b1;
                    out_exc   = 1'b1;
                end else begin
                    ireq_valid = 1'b1;
                end
            end
            WAIT: begin
                out_valid = iresp_valid;
                out_instr = iresp_data;
            end
            HOLD: begin
                out_valid = 1'b1;
                out_instr = buf_r;
            end
            DRAIN: begin
                out_valid = 1'b0;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // Next state and next PC; a redirect outranks every other event.
    always_comb begin
        next_state_s = state_r;
        next_pc_s    = pc_r;
        buf_load_s   = 1'b0;
        if (redirect_valid) begin
            next_pc_s = redirect_pc;
            case (state_r)
                REQ:     next_state_s = (ireq_valid && ireq_ready) ? DRAIN : REQ;
                WAIT:    next_state_s = iresp_valid ? REQ : DRAIN;
                HOLD:    next_state_s = REQ;
                // A response landing with the redirect still retires the outstanding request.
                DRAIN:   next_state_s = iresp_valid ? REQ : DRAIN;
                default: next_state_s = REQ;
            endcase
        end else if (accept_s) begin
            next_pc_s    = pc_r + 32'd4;
            next_state_s = REQ;
        end else begin
            case (state_r)
                REQ: begin
                    if (ireq_valid && ireq_ready) begin
                        next_state_s = WAIT;
                    end else begin
                        next_state_s = REQ;
                    end
                end
                WAIT: begin
                    if (iresp_valid) begin
                        buf_load_s   = 1'b1;
                        next_state_s = HOLD;
                    end else begin
                        next_state_s = WAIT;
                    end
                end
                HOLD: begin
                    next_state_s = HOLD;
                end
                DRAIN: begin
                    if (iresp_valid) begin
                        next_state_s = REQ;
                    end else begin
                        next_state_s = DRAIN;
                    end
                end
                default: begin
                    next_state_s = REQ;
                end
            endcase
        end
    end

    // State and PC registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= REQ;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= next_state_s;
            pc_r    <= next_pc_s;
        end
    end

    // Instruction buffer, loaded when a response arrives during a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_r <= 32'd0;
        end else if (buf_load_s) begin
            buf_r <= iresp_data;
        end else begin
            buf_r <= buf_r;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a transaction-level reference model.
module tb_fetch_ctrl;

    localparam logic [31:0] RPC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        is_usermode;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic [31:0] out_instr;
    logic        out_exc;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall), .is_usermode(is_usermode),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
        .iresp_valid(iresp_valid), .iresp_data(iresp_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_pcplus4(out_pcplus4),
        .out_instr(out_instr), .out_exc(out_exc)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: PC, whether a request is in flight, whether its answer is
    // unwanted (issued before a redirect), and whether an instruction is parked.
    logic [31:0] m_pc;
    logic [31:0] m_buf;
    bit          m_out;
    bit          m_stale;
    bit          m_have;

    // Bus model: one pending request with a countdown latency.
    bit          b_pend;
    int          b_cnt;
    logic [31:0] b_addr;

    int k_stall, k_redir, k_ready, k_lat, k_user;

    logic [31:0] targets [5];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic bit addr_bad(input logic [31:0] a, input bit um);
        return ((a % 32'd4) != 32'd0) || (um && (a >= 32'h8000_0000));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        stall          = 1'b0;
        is_usermode    = 1'b0;
        ireq_ready     = 1'b0;
        iresp_valid    = 1'b0;
        iresp_data     = 32'd0;
        m_pc = RPC; m_buf = 32'd0; m_out = 1'b0; m_stale = 1'b0; m_have = 1'b0;
        b_pend = 1'b0; b_cnt = 0; b_addr = 32'd0;
        #1;
        check("rst_ireq_valid", {31'd0, ireq_valid}, 32'd1);
        check("rst_ireq_addr", ireq_addr, RPC);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_exc", {31'd0, out_exc}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cycle();
        bit          e_req, e_val, e_exc, s_req;
        logic [31:0] e_instr, s_addr;
        @(negedge clk);
        stall          = ($urandom_range(99) < k_stall);
        redirect_valid = ($urandom_range(99) < k_redir);
        targets[4]     = {$urandom_range(32'h3fff_ffff), 2'b00};
        redirect_pc    = targets[$urandom_range(4)];
        ireq_ready     = ($urandom_range(99) < k_ready);
        if ($urandom_range(99) < k_user) is_usermode = ~is_usermode;
        iresp_valid    = b_pend && (b_cnt == 0);
        iresp_data     = iresp_valid ? instr_of(b_addr) : $urandom();
        #1;
        e_req = 1'b0; e_val = 1'b0; e_exc = 1'b0; e_instr = 32'd0;
        if (m_have) begin
            e_val = 1'b1; e_instr = m_buf;
        end else if (m_out) begin
            if (iresp_valid && !m_stale) begin
                e_val = 1'b1; e_instr = iresp_data;
            end
        end else if (addr_bad(m_pc, is_usermode)) begin
            e_val = 1'b1; e_exc = 1'b1;
        end else begin
            e_req = 1'b1;
        end
        check("ireq_valid", {31'd0, ireq_valid}, {31'd0, e_req});
        if (e_req) check("ireq_addr", ireq_addr, m_pc);
        check("out_valid", {31'd0, out_valid}, {31'd0, e_val});
        if (e_val) begin
            check("out_pc", out_pc, m_pc);
            check("out_pcplus4", out_pcplus4, m_pc + 32'd4);
            check("out_instr", out_instr, e_instr);
            check("out_exc", {31'd0, out_exc}, {31'd0, e_exc});
        end
        s_req  = ireq_valid && ireq_ready;
        s_addr = ireq_addr;
        @(posedge clk);
        if (redirect_valid) begin
            if (m_out && iresp_valid) m_out = 1'b0;
            else if (m_out) m_stale = 1'b1;
            else if (e_req && ireq_ready) begin m_out = 1'b1; m_stale = 1'b1; end
            m_pc   = redirect_pc;
            m_have = 1'b0;
        end else begin
            if (e_val && !stall) begin m_pc = m_pc + 32'd4; m_have = 1'b0; end
            if (m_out && iresp_valid) begin
                if (!m_stale && stall) begin m_have = 1'b1; m_buf = iresp_data; end
                m_out = 1'b0; m_stale = 1'b0;
            end else if (e_req && ireq_ready) begin
                m_out = 1'b1; m_stale = 1'b0;
            end
        end
        if (iresp_valid) b_pend = 1'b0;
        else if (b_pend) b_cnt--;
        if (s_req) begin
            check("single_outstanding", {31'd0, b_pend}, 32'd0);
            b_pend = 1'b1;
            b_cnt  = $urandom_range(k_lat);
            b_addr = s_addr;
        end
    endtask

    task automatic run(input int n, input int st, input int rd, input int rdy, input int lat, input int us);
        k_stall = st; k_redir = rd; k_ready = rdy; k_lat = lat; k_user = us;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        targets[0] = 32'h8000_1000;
        targets[1] = 32'h8000_0002;
        targets[2] = 32'h8000_0000;
        targets[3] = 32'hbfc0_0010;
        targets[4] = 32'h0000_0000;
        do_reset();
        run(20, 0, 0, 100, 0, 0);     // zero-wait streaming from reset
        run(600, 30, 10, 70, 3, 0);   // stalls, redirects, bus latency
        run(600, 25, 12, 60, 3, 5);   // privilege toggling
        do_reset();                   // reset mid-run
        run(400, 40, 15, 50, 2, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
